// File: rtl/gpr_mp_pkg.sv
// Shared CPU configuration for the multi-port register file: default widths,
// active-low control encodings and address-validity helper.
package gpr_mp_pkg;

  localparam int unsigned CPU_DATA_W  = 32;
  localparam int unsigned CPU_REG_NUM = 32;

  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;

  // True when an address names a real, writable register.
  function automatic logic addr_writable(input int unsigned addr,
                                         input int unsigned reg_num,
                                         input logic        zero_reg);
    return (addr < reg_num) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/gpr_mp_if.sv
// Bus bundle for the register file: read ports, two write ports, scoreboard lock.
interface gpr_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned RD_PORTS = 2
);
  localparam int unsigned ADDR_W = $clog2(REG_NUM);

  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       we0_;
  logic [ADDR_W-1:0]          wr_addr0;
  logic [DATA_W-1:0]          wr_data0;
  logic                       we1_;
  logic [ADDR_W-1:0]          wr_addr1;
  logic [DATA_W-1:0]          wr_data1;
  logic                       lock_;
  logic [ADDR_W-1:0]          lock_addr;
  logic [REG_NUM-1:0]         busy_vec;

  modport master (
    output rd_addr, we0_, wr_addr0, wr_data0, we1_, wr_addr1, wr_data1, lock_, lock_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, we0_, wr_addr0, wr_data0, we1_, wr_addr1, wr_data1, lock_, lock_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/gpr_mp_rd_port.sv
// One combinational read port: array lookup with write bypass and scoreboard lookup.
module gpr_rd_port
  import gpr_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned REG_NUM  = CPU_REG_NUM,
  parameter int unsigned ADDR_W   = $clog2(REG_NUM),
  parameter logic        ZERO_REG = 1'b1
) (
  input  logic              in_reset_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] regs_i [REG_NUM],
  input  logic [REG_NUM-1:0] busy_i,
  input  logic              we0_ok_i,
  input  logic [ADDR_W-1:0] wr_addr0_i,
  input  logic [DATA_W-1:0] wr_data0_i,
  input  logic              we1_ok_i,
  input  logic [ADDR_W-1:0] wr_addr1_i,
  input  logic [DATA_W-1:0] wr_data1_i,
  input  logic              lock_ok_i,
  input  logic [ADDR_W-1:0] lock_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);

  logic readable;
  logic byp0, byp1, lock_hit;

  always_comb begin
    readable = !in_reset_i && addr_writable(32'(rd_addr_i), REG_NUM, ZERO_REG);
    byp0     = we0_ok_i  && (wr_addr0_i  == rd_addr_i);
    byp1     = we1_ok_i  && (wr_addr1_i  == rd_addr_i);
    lock_hit = lock_ok_i && (lock_addr_i == rd_addr_i);
  end

  // A bypassed write clears the reported busy unless a same-cycle lock re-arms it.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (readable) begin
      if (byp1)      rd_data_o = wr_data1_i;
      else if (byp0) rd_data_o = wr_data0_i;
      else           rd_data_o = regs_i[rd_addr_i];
      rd_busy_o = busy_i[rd_addr_i] && !((byp0 || byp1) && !lock_hit);
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general purpose register file with a per-register busy scoreboard.
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned REG_NUM  = CPU_REG_NUM,
  parameter int unsigned RD_PORTS = 2,
  parameter logic        ZERO_REG = 1'b1
) (
  input logic     clk,
  input logic     reset,
  gpr_mp_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(REG_NUM);

  logic [DATA_W-1:0]  regs_q [REG_NUM];
  logic [DATA_W-1:0]  regs_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;

  logic in_reset, we0_ok, we1_ok, lock_ok;

  always_comb begin
    in_reset = (reset == RESET_ENABLE);
    we0_ok   = !in_reset && (bus.we0_  == ENABLE_) &&
               addr_writable(32'(bus.wr_addr0), REG_NUM, ZERO_REG);
    we1_ok   = !in_reset && (bus.we1_  == ENABLE_) &&
               addr_writable(32'(bus.wr_addr1), REG_NUM, ZERO_REG);
    lock_ok  = !in_reset && (bus.lock_ == ENABLE_) &&
               addr_writable(32'(bus.lock_addr), REG_NUM, ZERO_REG);
  end

  // Port 1 is applied after port 0 so it wins a same-address collision; lock last so it wins over clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0_ok) begin
      regs_d[bus.wr_addr0] = bus.wr_data0;
      busy_d[bus.wr_addr0] = 1'b0;
    end
    if (we1_ok) begin
      regs_d[bus.wr_addr1] = bus.wr_data1;
      busy_d[bus.wr_addr1] = 1'b0;
    end
    if (lock_ok) busy_d[bus.lock_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  logic [DATA_W-1:0] rd_data_w [RD_PORTS];
  logic [RD_PORTS-1:0] rd_busy_w;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    gpr_rd_port #(
      .DATA_W  (DATA_W),
      .REG_NUM (REG_NUM),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .in_reset_i(in_reset),
      .rd_addr_i (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .we0_ok_i  (we0_ok),
      .wr_addr0_i(bus.wr_addr0),
      .wr_data0_i(bus.wr_data0),
      .we1_ok_i  (we1_ok),
      .wr_addr1_i(bus.wr_addr1),
      .wr_data1_i(bus.wr_data1),
      .lock_ok_i (lock_ok),
      .lock_addr_i(bus.lock_addr),
      .rd_data_o (rd_data_w[k]),
      .rd_busy_o (rd_busy_w[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int unsigned k = 0; k < RD_PORTS; k++) bus.rd_data[k*DATA_W +: DATA_W] = rd_data_w[k];
    bus.rd_busy = rd_busy_w;
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Directed plus randomized checks of gpr_mp against a behavioural register/scoreboard model.
module tb_gpr_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned RN = 32;
  localparam int unsigned RP = 2;

  logic clk = 1'b0;
  logic reset;

  gpr_mp_if #(.DATA_W(DW), .REG_NUM(RN), .RD_PORTS(RP)) bus ();

  gpr_mp #(.DATA_W(DW), .REG_NUM(RN), .RD_PORTS(RP), .ZERO_REG(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32];
  logic [31:0] busy_m;

  logic        e0, e1, lk;
  logic [4:0]  a0, a1, la;
  logic [4:0]  ra [2];
  logic [31:0] d0, d1;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic w0i, input logic [4:0] a0i, input logic [31:0] d0i,
                       input logic w1i, input logic [4:0] a1i, input logic [31:0] d1i,
                       input logic lki, input logic [4:0] lai,
                       input logic [4:0] r0i, input logic [4:0] r1i);
    e0 = w0i; a0 = a0i; d0 = d0i;
    e1 = w1i; a1 = a1i; d1 = d1i;
    lk = lki; la = lai;
    ra[0] = r0i; ra[1] = r1i;
    bus.we0_ = ~w0i; bus.wr_addr0 = a0i; bus.wr_data0 = d0i;
    bus.we1_ = ~w1i; bus.wr_addr1 = a1i; bus.wr_data1 = d1i;
    bus.lock_ = ~lki; bus.lock_addr = lai;
    bus.rd_addr = {r1i, r0i};
  endtask

  task automatic idle(input logic [4:0] r0i, input logic [4:0] r1i);
    apply(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, r0i, r1i);
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!reset || a == 0) return '0;
    if (e1 && a1 == a) return d1;
    if (e0 && a0 == a) return d0;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!reset || a == 0) return 1'b0;
    if (((e1 && a1 == a) || (e0 && a0 == a)) && !(lk && la == a)) return 1'b0;
    return busy_m[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    busy_m = '0;
  endtask

  task automatic model_edge();
    if (!reset) clear_model();
    else begin
      if (e0 && a0 != 0) begin mem[a0] = d0; busy_m[a0] = 1'b0; end
      if (e1 && a1 != 0) begin mem[a1] = d1; busy_m[a1] = 1'b0; end
      if (lk && la != 0) busy_m[la] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check32({tag, "_rd_data"}, bus.rd_data[k*32 +: 32], exp_data(ra[k]));
      check32({tag, "_rd_busy"}, {31'b0, bus.rd_busy[k]}, {31'b0, exp_busy(ra[k])});
    end
    check32({tag, "_busy_vec"}, bus.busy_vec, reset ? busy_m : 32'h0);
  endtask

  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    clear_model();
    reset = 1'b1;
    idle(5'd5, 5'd5);
    #1 reset = 1'b0;

    // Reset state
    #1;
    check32("rst_r5_p0", bus.rd_data[31:0], 32'h0);
    check32("rst_r5_p1", bus.rd_data[63:32], 32'h0);
    check32("rst_busy_vec", bus.busy_vec, 32'h0);
    step("rst");
    reset = 1'b1;
    idle(5'd5, 5'd5);
    step("idle");

    // Same-cycle bypass, then stored value
    apply(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd3, 5'd1);
    #1 check32("r3_bypass", bus.rd_data[31:0], 32'hDEADBEEF);
    step("r3_wr");
    idle(5'd3, 5'd3);
    #1 check32("r3_stored", bus.rd_data[31:0], 32'hDEADBEEF);
    step("r3_rd");

    // Write collision: port 1 wins
    apply(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 5'd7);
    #1 check32("r7_bypass", bus.rd_data[63:32], 32'h22222222);
    step("r7_wr");
    idle(5'd7, 5'd3);
    #1 check32("r7_stored", bus.rd_data[31:0], 32'h22222222);
    step("r7_rd");

    // Register zero is hard-wired
    apply(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    #1 check32("r0_nobypass", bus.rd_data[31:0], 32'h0);
    step("r0_wr");
    idle(5'd0, 5'd0);
    #1 check32("r0_busy", {31'b0, bus.busy_vec[0]}, 32'h0);
    check32("r0_data", bus.rd_data[31:0], 32'h0);
    step("r0_rd");

    // Scoreboard lock / write interplay
    apply(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    step("r9_lock");
    idle(5'd9, 5'd9);
    #1 check32("r9_busy_set", {31'b0, bus.busy_vec[9]}, 32'h1);
    check32("r9_rd_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
    step("r9_idle");
    apply(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    #1 check32("r9_wr_lock_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
    step("r9_wr_lock");
    idle(5'd9, 5'd9);
    #1 check32("r9_still_busy", {31'b0, bus.busy_vec[9]}, 32'h1);
    check32("r9_data", bus.rd_data[31:0], 32'h55);
    step("r9_idle2");
    apply(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd9, 5'd9);
    #1 check32("r9_wr_byp_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    step("r9_wr");
    idle(5'd9, 5'd9);
    #1 check32("r9_busy_clr", {31'b0, bus.busy_vec[9]}, 32'h0);
    step("r9_idle3");

    // Fill r1..r31, then reset mid-cycle
    for (int i = 1; i < 32; i += 2) begin
      apply(1'b1, 5'(i), 32'(i), 1'b1, 5'(i + 1), 32'(i + 1), 1'b1, 5'(i + 2), 5'(i), 5'(i - 1));
      step("fill");
    end
    idle(5'd31, 5'd17);
    step("fill_rd");
    apply(1'b1, 5'd4, 32'hAAAA, 1'b0, 5'd0, '0, 1'b1, 5'd4, 5'd4, 5'd31);
    #2 reset = 1'b0;
    #1;
    check32("midrst_p0", bus.rd_data[31:0], 32'h0);
    check32("midrst_p1", bus.rd_data[63:32], 32'h0);
    check32("midrst_busy", bus.busy_vec, 32'h0);
    clear_model();
    @(posedge clk);
    model_edge();
    #1;
    apply(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd4, 5'd4);
    reset = 1'b1;
    step("rel_wr");
    idle(5'd4, 5'd5);
    #1 check32("r4_after_rst", bus.rd_data[31:0], 32'h4);
    check32("r5_after_rst", bus.rd_data[63:32], 32'h0);
    step("rel_rd");

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = $urandom_range(0, 1) == 1;
      apply($urandom_range(0, 2) != 0,
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)), $urandom(),
            $urandom_range(0, 2) == 0,
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)), $urandom(),
            $urandom_range(0, 2) == 0,
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        clear_model();
      end else begin
        reset = 1'b1;
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
